// File: rtl/y_alu.sv
// Registered WIDTH-bit ALU (AND/OR/ADD/SUB/SLT) with zero flag, one-cycle latency.
// Optional registered overflow output is enabled by defining YALU_OVF_EN.
module y_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             ex,
`ifdef YALU_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic             lt;
  logic [WIDTH-1:0] result;
  logic             result_ovf;

  // One shared adder: op[2] selects subtract via inverted b and carry-in of 1.
  always_comb begin
    b_eff   = op[2] ? ~b : b;
    sum     = a + b_eff + WIDTH'(op[2]);
    add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    lt      = sum[WIDTH-1] ^ add_ovf;
  end

  always_comb begin
    result     = '0;
    result_ovf = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result     = sum;
        result_ovf = add_ovf;
      end
      OP_SUB: begin
        result     = sum;
        result_ovf = add_ovf;
      end
      OP_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z         <= '0;
      ex        <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      z         <= result;
      ex        <= (result == '0);
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef YALU_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= result_ovf;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = result_ovf;
`endif

endmodule

// File: tb/tb_y_alu.sv
// Self-checking bench for y_alu: directed corner cases plus randomized stream
// against an arithmetic reference model.
module tb_y_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic [31:0] z;
  logic        ex;
  logic        out_valid;
`ifdef YALU_OVF_EN
  logic        ovf;
`endif

  int unsigned n_cmp;
  int unsigned n_err;
  logic [31:0] last_z;
  logic        last_ex;
  logic        last_ovf;

  y_alu #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .op(op),
    .z(z),
    .ex(ex),
`ifdef YALU_OVF_EN
    .ovf(ovf),
`endif
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_z(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] o);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x + y;
      3'd6: return x - y;
      3'd7: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Overflow judged by whether the exact signed result fits in 32 bits.
  function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic [2:0] o);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 3'd2) r = sx + sy;
    else if (o == 3'd6) r = sx - sy;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Called at a negedge; applies one valid op and checks it one cycle later.
  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [2:0] o);
    a = x; b = y; op = o; in_valid = 1'b1;
    last_z   = ref_z(x, y, o);
    last_ex  = (last_z == 32'd0);
    last_ovf = ref_ovf(x, y, o);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".z"}, z, last_z);
    check({tag, ".ex"}, {31'd0, ex}, {31'd0, last_ex});
    check({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
`ifdef YALU_OVF_EN
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, last_ovf});
`endif
  endtask

  task automatic idle_check(input string tag);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".z"}, z, last_z);
    check({tag, ".ex"}, {31'd0, ex}, {31'd0, last_ex});
    check({tag, ".vld"}, {31'd0, out_valid}, 32'd0);
`ifdef YALU_OVF_EN
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, last_ovf});
`endif
  endtask

  initial begin
    logic [2:0] ops [4];
    ops = '{3'd0, 3'd1, 3'd2, 3'd6};
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
    last_z = '0; last_ex = 1'b0; last_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.z", z, 32'd0);
    check("rst.ex", {31'd0, ex}, 32'd0);
    check("rst.vld", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    idle_check("idle");

    run("and", 32'hF0F0_1234, 32'h0FF0_FF00, 3'd0);
    check("and.lit", z, 32'h00F0_1200);
    run("or", 32'hF0F0_1234, 32'h0FF0_FF00, 3'd1);
    check("or.lit", z, 32'hFFF0_FF34);
    run("addwrap", 32'hFFFF_FFFF, 32'd1, 3'd2);
    check("addwrap.ex", {31'd0, ex}, 32'd1);
    run("addovf", 32'h7FFF_FFFF, 32'd1, 3'd2);
    check("addovf.lit", z, 32'h8000_0000);
    run("subzero", 32'h1234_5678, 32'h1234_5678, 3'd6);
    run("subneg", 32'd5, 32'd7, 3'd6);
    check("subneg.lit", z, 32'hFFFF_FFFE);
    run("subovf", 32'h8000_0000, 32'd1, 3'd6);
    run("slt_ovf", 32'h8000_0000, 32'd1, 3'd7);
    check("slt_ovf.lit", z, 32'd1);
    run("slt_ovf2", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd7);
    check("slt_ovf2.ex", {31'd0, ex}, 32'd1);
    run("op3", 32'hDEAD_BEEF, 32'h1234_5678, 3'd3);
    run("op4", 32'hDEAD_BEEF, 32'h1234_5678, 3'd4);
    run("op5", 32'hDEAD_BEEF, 32'h1234_5678, 3'd5);
    idle_check("hold0");

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 10; j++)
        run("stream", $urandom, $urandom, ops[i]);
    idle_check("hold1");
    idle_check("hold2");

    for (int j = 0; j < 40; j++)
      run("rnd", $urandom, (j % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom, 3'($urandom));

    // Asynchronous reset between edges, with an operation in flight.
    a = 32'd3; b = 32'd4; op = 3'd2; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst.z", z, 32'd0);
    check("arst.ex", {31'd0, ex}, 32'd0);
    check("arst.vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("arst.drop", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_z = '0; last_ex = 1'b0; last_ovf = 1'b0;
    idle_check("post_rst");
    run("post_op", 32'd9, 32'd9, 3'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
